// File: rtl/lane_serializer_if.sv
// Bus between a word producer and lane_serializer. data_i moves on a rising edge
// where valid_i && ready_o; ready_o never depends on valid_i. data_o is a beat only while valid_o is 1.
interface lane_serializer_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 1
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             msb_first_i;
    logic             underrun_clr_i;
    logic [LANES-1:0] data_o;
    logic             valid_o;
    logic             sof_o;
    logic             underrun_o;
    logic             fsm_shift;   // debug: 1 while the serializer FSM is in SHIFT

    modport master (
        output data_i, valid_i, msb_first_i, underrun_clr_i,
        input  ready_o, data_o, valid_o, sof_o, underrun_o, fsm_shift
    );

    modport slave (
        input  data_i, valid_i, msb_first_i, underrun_clr_i,
        output ready_o, data_o, valid_o, sof_o, underrun_o, fsm_shift
    );
endinterface

// File: rtl/lane_serializer.sv
// Parallel-to-serial converter: one holding register feeds a shift register that emits
// LANES bits per cycle, MSB- or LSB-first, with registered beat outputs and a sticky underrun flag.
module lane_serializer #(
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    lane_serializer_if.slave   bus
);
    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    generate
        if (((WIDTH % LANES) != 0) || (BEATS < 2)) begin : g_bad_params
            $error("lane_serializer: WIDTH must be a multiple of LANES giving at least two beats");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_word;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic             msb_mode;

    logic             last_beat;
    logic             load;
    logic             accept;
    logic [LANES-1:0] beat;

    assign last_beat     = (state == SHIFT) && (cnt == LAST);
    assign load          = hold_full && ((state == IDLE) || last_beat);
    assign bus.ready_o   = !hold_full || load;
    assign accept        = bus.valid_i && bus.ready_o;
    assign bus.fsm_shift = (state == SHIFT);

    // The shifter moves the next beat to the edge that matches the latched order.
    assign beat = msb_mode ? shreg[WIDTH-1 -: LANES] : shreg[LANES-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_word <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_word <= bus.data_i;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            shreg          <= '0;
            msb_mode       <= 1'b0;
            bus.data_o     <= '0;
            bus.valid_o    <= 1'b0;
            bus.sof_o      <= 1'b0;
            bus.underrun_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.data_o  <= '0;
                    bus.valid_o <= 1'b0;
                    bus.sof_o   <= 1'b0;
                    if (hold_full) begin
                        shreg    <= hold_word;
                        msb_mode <= bus.msb_first_i;
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bus.data_o  <= beat;
                    bus.valid_o <= 1'b1;
                    bus.sof_o   <= (cnt == '0);
                    if (load) begin
                        shreg    <= hold_word;
                        msb_mode <= bus.msb_first_i;
                        cnt      <= '0;
                    end else if (last_beat) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        shreg <= msb_mode ? (shreg << LANES) : (shreg >> LANES);
                    end
                end
                default: state <= IDLE;
            endcase

            // Setting wins over a coincident clear so a fresh gap is never lost.
            if (last_beat && !hold_full)
                bus.underrun_o <= 1'b1;
            else if (bus.underrun_clr_i)
                bus.underrun_o <= 1'b0;
        end
    end
endmodule
